// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - store aligner with byte enables feeding a small write FIFO.
// Optional tail merging of same-word stores: define STORE_ALIGN_BUFFER_MERGE_EN.
module store_align_buffer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic              legal;
  logic [31:0]       wdata_n;
  logic [3:0]        be_n;
  logic [ADDR_W-1:0] word_addr;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;

  assign word_addr = {in_addr[ADDR_W-1:2], 2'b00};
  assign full      = (count >= CW'(DEPTH));

  always_comb begin
    legal   = 1'b0;
    wdata_n = in_data;
    be_n    = 4'b0000;
    case (in_size)
      2'b00: begin
        legal   = 1'b1;
        wdata_n = {4{in_data[7:0]}};
        be_n    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        legal   = ~in_addr[0];
        wdata_n = {2{in_data[15:0]}};
        be_n    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal   = (in_addr[1:0] == 2'b00);
        wdata_n = in_data;
        be_n    = 4'b1111;
      end
      default: begin
        legal   = 1'b0;
        wdata_n = in_data;
        be_n    = 4'b0000;
      end
    endcase
  end

`ifdef STORE_ALIGN_BUFFER_MERGE_EN
  logic [PW-1:0] tail_ptr;
  logic          merge_ok;
  logic          merge_do;
  logic [31:0]   merged;

  // Tail must not be the presented head, hence count >= 2.
  assign tail_ptr = wr_ptr - PW'(1);
  assign merge_ok = legal && (count >= CW'(2)) && (addr_q[tail_ptr] == word_addr);
  assign in_ready = !full || merge_ok;
  assign accept   = in_valid && in_ready;
  assign merge_do = accept && merge_ok;
  assign push     = accept && legal && !merge_ok;

  always_comb begin
    merged = data_q[tail_ptr];
    for (int i = 0; i < 4; i++) begin
      if (be_n[i]) merged[8*i +: 8] = wdata_n[8*i +: 8];
    end
  end
`else
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
`endif

  assign pop       = mem_valid && mem_ready;
  assign mem_valid = (count != '0);
  assign mem_addr  = addr_q[rd_ptr];
  assign mem_wdata = data_q[rd_ptr];
  assign mem_be    = be_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      misalign_err <= accept && !legal;
      if (push) begin
        addr_q[wr_ptr] <= word_addr;
        data_q[wr_ptr] <= wdata_n;
        be_q[wr_ptr]   <= be_n;
        wr_ptr         <= wr_ptr + PW'(1);
      end
`ifdef STORE_ALIGN_BUFFER_MERGE_EN
      if (merge_do) begin
        data_q[tail_ptr] <= merged;
        be_q[tail_ptr]   <= be_q[tail_ptr] | be_n;
      end
`endif
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - directed self-checking bench for store_align_buffer.
module tb_store_align_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign_err;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  store_align_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign_err(misalign_err), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = 1'b1; in_addr = a; in_data = d; in_size = s;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 8 && count != 2'd0; i++) @(negedge clk);
    checks++;
    if (count !== 2'd0) begin failures++; $display("FAIL drain count got=%0d exp=0", count); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_be); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", misalign_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_store_byte();
    mem_ready = 1'b1;
    send(32'h1003, 32'hFFFFFFAB, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL sb_valid got=%b exp=1", mem_valid); end
    checks++; if (mem_addr !== 32'h1000) begin failures++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
    checks++; if (mem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", mem_wdata); end
    checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
    @(negedge clk);
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL sb_count_after got=%0d exp=0", count); end
    mem_ready = 1'b0;
  endtask

  task automatic test_store_half();
    mem_ready = 1'b0;
    send(32'h2002, 32'h00001234, 2'b01);
    @(negedge clk);
    send(32'h2200, 32'hABCD5678, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL sh_count got=%0d exp=2", count); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h2000, 32'h12341234, 4'b1100}) begin
      failures++; $display("FAIL sh_hi got=%h/%h/%b exp=00002000/12341234/1100", mem_addr, mem_wdata, mem_be); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h2200, 32'h56785678, 4'b0011}) begin
      failures++; $display("FAIL sh_lo got=%h/%h/%b exp=00002200/56785678/0011", mem_addr, mem_wdata, mem_be); end
    drain();
  endtask

  task automatic test_misalign();
    logic [31:0] a [3];
    logic [1:0]  s [3];
    a[0] = 32'h3001; s[0] = 2'b10;
    a[1] = 32'h3003; s[1] = 2'b01;
    a[2] = 32'h3000; s[2] = 2'b11;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(a[i], 32'hDEADBEEF, s[i]);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_pulse[%0d] got=%b exp=1", i, misalign_err); end
      checks++; if (mem_valid !== 1'b0 || count !== 2'd0) begin
        failures++; $display("FAIL misalign_noq[%0d] got valid=%b count=%0d exp=0/0", i, mem_valid, count); end
      @(negedge clk);
      checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_width[%0d] got=%b exp=0", i, misalign_err); end
    end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    send(32'h10, 32'hA0000010, 2'b10);
    @(negedge clk);
    send(32'h20, 32'hA0000020, 2'b10);
    @(negedge clk);
    send(32'h30, 32'hA0000030, 2'b10);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin
      failures++; $display("FAIL bp_full got in_ready=%b count=%0d exp=0/2", in_ready, count); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hA0000010) begin
      failures++; $display("FAIL bp_hold got=%h/%h exp=00000010/a0000010", mem_addr, mem_wdata); end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'hA0000020 || count !== 2'd1) begin
      failures++; $display("FAIL bp_second got=%h/%h count=%0d exp=00000020/a0000020/1", mem_addr, mem_wdata, count); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (mem_addr !== 32'h30 || mem_wdata !== 32'hA0000030 || count !== 2'd1) begin
      failures++; $display("FAIL bp_third got=%h/%h count=%0d exp=00000030/a0000030/1", mem_addr, mem_wdata, count); end
    @(negedge clk);
    checks++; if (count !== 2'd0 || mem_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got count=%0d valid=%b exp=0/0", count, mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    send(32'h40, 32'h1, 2'b10);
    @(negedge clk);
    send(32'h50, 32'h2, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL ar_pre_count got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || count !== 2'd0) begin
      failures++; $display("FAIL ar_immediate got valid=%b count=%0d exp=0/0", mem_valid, count); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || mem_valid !== 1'b0) begin
      failures++; $display("FAIL ar_after got in_ready=%b valid=%b exp=1/0", in_ready, mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_merge();
    mem_ready = 1'b0;
    send(32'h100, 32'h11111111, 2'b10);
    @(negedge clk);
    send(32'h200, 32'h00000000, 2'b10);
    @(negedge clk);
    send(32'h201, 32'h000000CC, 2'b00);
`ifdef STORE_ALIGN_BUFFER_MERGE_EN
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL merge_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL merge_count got=%0d exp=2", count); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h200, 32'h0000CC00, 4'b1111}) begin
      failures++; $display("FAIL merge_entry got=%h/%h/%b exp=00000200/0000cc00/1111", mem_addr, mem_wdata, mem_be); end
`else
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL nomerge_stall got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin
      failures++; $display("FAIL nomerge_hold got count=%0d in_ready=%b exp=2/0", count, in_ready); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h200, 32'h00000000, 4'b1111} || count !== 2'd2) begin
      failures++; $display("FAIL nomerge_entry got=%h/%h/%b count=%0d exp=00000200/00000000/1111/2", mem_addr, mem_wdata, mem_be, count); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h200, 32'hCCCCCCCC, 4'b0010}) begin
      failures++; $display("FAIL nomerge_sb got=%h/%h/%b exp=00000200/cccccccc/0010", mem_addr, mem_wdata, mem_be); end
`endif
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store_byte();
    test_store_half();
    test_misalign();
    test_back_to_back();
    test_async_reset();
    test_merge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
